// File: rtl/bus_synchronizer.sv
// ---------------------------------------------------------------------------
// bus_synchronizer
//
// Purpose:
//   Carries bundled data words from an asynchronous source domain into the
//   clk_dest domain using a per-channel toggle request / toggle acknowledge
//   handshake. Only the request line of each channel is synchronized. The
//   data bits are sampled directly, because the source holds them stable
//   from its request toggle until it sees the matching acknowledge toggle.
//   Each channel buffers one presented word plus one parked request.
//
// Parameters:
//   BITS_WIDTH    data word width per channel
//   CHANNELS      number of independent crossing channels
//   STAGES        synchronizer depth on each request line (minimum 2)
//
// Ports:
//   clk_dest      destination clock, rising edge only
//   rst           synchronous active-high reset
//   src_req       per-channel request toggles (asynchronous to clk_dest)
//   data_src      per-channel bundled data, channel i at [i*BITS_WIDTH +: BITS_WIDTH]
//   src_ack       per-channel acknowledge toggles back to the source
//   data_dest     captured words, same slicing as data_src
//   dest_valid    per-channel "data_dest holds an unconsumed word"
//   dest_ready    per-channel consumer accept
//   overrun       sticky per-channel protocol-violation flag
//   clear_overrun clears all overrun flags (a new overrun in the same cycle wins)
// ---------------------------------------------------------------------------
module bus_synchronizer #(
    parameter int BITS_WIDTH = 5,
    parameter int CHANNELS   = 1,
    parameter int STAGES     = 2
) (
    input  logic                           clk_dest,
    input  logic                           rst,
    input  logic [CHANNELS-1:0]            src_req,
    input  logic [CHANNELS*BITS_WIDTH-1:0] data_src,
    output logic [CHANNELS-1:0]            src_ack,
    output logic [CHANNELS*BITS_WIDTH-1:0] data_dest,
    output logic [CHANNELS-1:0]            dest_valid,
    input  logic [CHANNELS-1:0]            dest_ready,
    output logic [CHANNELS-1:0]            overrun,
    input  logic                           clear_overrun
);

    // Per-channel buffer state. EMPTY has nothing to present, FULL presents
    // one word, FULL_PEND presents one word and also has a request parked
    // that has not been acknowledged yet.
    typedef enum logic [1:0] {
        ST_EMPTY     = 2'd0,
        ST_FULL      = 2'd1,
        ST_FULL_PEND = 2'd2
    } state_t;

    for (genvar g = 0; g < CHANNELS; g++) begin : gChannel

        logic [STAGES-1:0]     r_sync;
        logic                  r_reqD;
        logic                  r_ack;
        logic                  r_valid;
        logic                  r_overrun;
        logic [BITS_WIDTH-1:0] r_data;
        state_t                r_state;

        logic                  w_syncOut;
        logic                  w_edge;
        logic [BITS_WIDTH-1:0] w_dataIn;

        // The last synchronizer flop is compared with one extra delayed copy,
        // so every toggle of src_req, in either direction, yields exactly one
        // single-cycle edge pulse.
        assign w_syncOut = r_sync[STAGES-1];
        assign w_edge    = w_syncOut ^ r_reqD;
        assign w_dataIn  = data_src[g*BITS_WIDTH +: BITS_WIDTH];

        // Synchronizer chain, edge detector and the channel buffer FSM.
        // All outputs are registered here. data_dest is written only when a
        // word is captured, so it keeps the last word after dest_valid falls.
        // A capture always toggles the acknowledge. A request that arrives
        // while one is already parked is dropped without an acknowledge and
        // only raises the sticky overrun flag.
        always_ff @(posedge clk_dest) begin
            if (rst) begin
                r_sync    <= '0;
                r_reqD    <= 1'b0;
                r_ack     <= 1'b0;
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
                r_data    <= '0;
                r_state   <= ST_EMPTY;
            end else begin
                r_sync <= {r_sync[STAGES-2:0], src_req[g]};
                r_reqD <= w_syncOut;

                if (clear_overrun) begin
                    r_overrun <= 1'b0;
                end

                case (r_state)
                    ST_EMPTY: begin
                        if (w_edge) begin
                            r_data  <= w_dataIn;
                            r_valid <= 1'b1;
                            r_ack   <= ~r_ack;
                            r_state <= ST_FULL;
                        end
                    end

                    ST_FULL: begin
                        if (w_edge && dest_ready[g]) begin
                            r_data  <= w_dataIn;
                            r_valid <= 1'b1;
                            r_ack   <= ~r_ack;
                        end else if (w_edge) begin
                            r_state <= ST_FULL_PEND;
                        end else if (dest_ready[g]) begin
                            r_valid <= 1'b0;
                            r_state <= ST_EMPTY;
                        end
                    end

                    ST_FULL_PEND: begin
                        if (dest_ready[g]) begin
                            r_data  <= w_dataIn;
                            r_valid <= 1'b1;
                            r_ack   <= ~r_ack;
                            r_state <= ST_FULL;
                        end
                        if (w_edge) begin
                            r_overrun <= 1'b1;
                        end
                    end

                    default: begin
                        r_valid <= 1'b0;
                        r_state <= ST_EMPTY;
                    end
                endcase
            end
        end

        assign src_ack[g]                              = r_ack;
        assign dest_valid[g]                           = r_valid;
        assign overrun[g]                              = r_overrun;
        assign data_dest[g*BITS_WIDTH +: BITS_WIDTH]   = r_data;

    end

endmodule
